// File: rtl/ldpc_ber_tester_up_axi.sv
// AXI4-Lite slave bridging CPU accesses onto the tester up_* register bus.
// Independent read/write channels; a missing ack times out into SLVERR.
module ldpc_ber_tester_up_axi #(
    parameter int ADDRESS_WIDTH  = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       up_clk,
    input  logic                       up_resetn,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [ADDRESS_WIDTH+1:0]   s_axi_awaddr,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    output logic [1:0]                 s_axi_bresp,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    input  logic [ADDRESS_WIDTH+1:0]   s_axi_araddr,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       up_wreq,
    output logic [ADDRESS_WIDTH-1:0]   up_waddr,
    output logic [31:0]                up_wdata,
    input  logic                       up_wack,
    output logic                       up_rreq,
    output logic [ADDRESS_WIDTH-1:0]   up_raddr,
    input  logic [31:0]                up_rdata,
    input  logic                       up_rack
);

    localparam int AW = ADDRESS_WIDTH;
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;

    w_state_t    w_state;
    w_state_t    w_next;
    logic [15:0] w_cnt;
    logic        w_start;
    logic        w_ok;
    logic        w_tmo;

    r_state_t    r_state;
    r_state_t    r_next;
    logic [15:0] r_cnt;
    logic        r_start;
    logic        r_ok;
    logic        r_tmo;

    // Byte-lane strobes and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        w_next  = w_state;
        w_start = 1'b0;
        w_ok    = 1'b0;
        w_tmo   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_start = 1'b1;
                    w_next  = W_ACK;
                end
            end
            W_ACK: begin
                if (up_wack) begin
                    w_ok   = 1'b1;
                    w_next = W_RESP;
                end else if (w_cnt == TMO) begin
                    w_tmo  = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (!up_resetn) begin
            w_state       <= W_IDLE;
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            up_wreq       <= 1'b0;
            up_waddr      <= '0;
            up_wdata      <= '0;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= w_start;
            s_axi_wready  <= w_start;
            up_wreq       <= w_start;
            if (w_start) begin
                up_waddr <= s_axi_awaddr[AW+1:2];
                up_wdata <= s_axi_wdata;
            end
            if (w_state == W_ACK && w_next == W_ACK) begin
                w_cnt <= w_cnt + 16'd1;
            end else begin
                w_cnt <= '0;
            end
            if (w_ok || w_tmo) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= w_tmo ? SLVERR : OKAY;
            end else if (w_state == W_RESP && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        r_next  = r_state;
        r_start = 1'b0;
        r_ok    = 1'b0;
        r_tmo   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_start = 1'b1;
                    r_next  = R_ACK;
                end
            end
            R_ACK: begin
                if (up_rack) begin
                    r_ok   = 1'b1;
                    r_next = R_RESP;
                end else if (r_cnt == TMO) begin
                    r_tmo  = 1'b1;
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (!up_resetn) begin
            r_state       <= R_IDLE;
            r_cnt         <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= OKAY;
            s_axi_rdata   <= '0;
            up_rreq       <= 1'b0;
            up_raddr      <= '0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= r_start;
            up_rreq       <= r_start;
            if (r_start) begin
                up_raddr <= s_axi_araddr[AW+1:2];
            end
            if (r_state == R_ACK && r_next == R_ACK) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
            if (r_ok) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= OKAY;
                s_axi_rdata  <= up_rdata;
            end else if (r_tmo) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= SLVERR;
                s_axi_rdata  <= '0;
            end else if (r_state == R_RESP && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
